// File: rtl/prim_clock_switch_ctrl.sv
// Sequencer for a glitch-free N-input clock selection network: gates all buffers,
// drains the old clock, moves the mux select, settles, then enables the new source.
module prim_clock_switch_ctrl #(
   parameter int unsigned NumClks    = 4,
   parameter int unsigned SelW       = $clog2(NumClks),
   parameter int unsigned GateCycles = 4,
   parameter int unsigned DefaultSel = 0
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req_i,
   input  logic [SelW-1:0]    sel_i,
   output logic               ack_o,
   output logic               err_o,
   output logic               busy_o,
   output logic [SelW-1:0]    sel_o,
   output logic [NumClks-1:0] en_o
);

   typedef enum logic [1:0] {
      StIdle,
      StDrain,
      StSettle
   } state_e;

   localparam logic [7:0]         CntInit = 8'(GateCycles - 1);
   localparam logic [SelW-1:0]    DefSel  = SelW'(DefaultSel);
   localparam logic [NumClks-1:0] DefEn   = NumClks'(1) << DefaultSel;

   state_e               state_q, state_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [SelW-1:0]      tgt_q, tgt_d;
   logic [SelW-1:0]      sel_q, sel_d;
   logic [NumClks-1:0]   en_q, en_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic                 sel_bad;

   assign sel_bad = (32'(sel_i) >= NumClks);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         tgt_q   <= DefSel;
         sel_q   <= DefSel;
         en_q    <= DefEn;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      sel_d   = sel_q;
      en_d    = en_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      busy_d  = busy_q;
      unique case (state_q)
         StIdle: begin
            if (req_i) begin
               if (sel_bad) begin
                  err_d = 1'b1;
               end else if (sel_i == sel_q) begin
                  ack_d = 1'b1;
               end else begin
                  tgt_d   = sel_i;
                  en_d    = '0;
                  cnt_d   = CntInit;
                  busy_d  = 1'b1;
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            // The select only ever moves here, with every buffer already gated off.
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               sel_d   = tgt_q;
               cnt_d   = CntInit;
               state_d = StSettle;
            end
         end
         StSettle: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               en_d    = NumClks'(1) << tgt_q;
               ack_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign ack_o  = ack_q;
   assign err_o  = err_q;
   assign busy_o = busy_q;
   assign sel_o  = sel_q;
   assign en_o   = en_q;

endmodule

// File: tb/tb_prim_clock_switch_ctrl.sv
// Bench for prim_clock_switch_ctrl: directed scenarios plus random requests,
// compared each cycle against a timeline model of the switch sequence.
module tb_prim_clock_switch_ctrl;

   localparam int N   = 5;
   localparam int G   = 3;
   localparam int DEF = 2;
   localparam int SW  = $clog2(N);

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          req    = 1'b0;
   logic [SW-1:0] sel_in = '0;
   logic          ack, err, busy;
   logic [SW-1:0] sel_out;
   logic [N-1:0]  en;

   int n_cmp = 0;
   int n_bad = 0;
   int n_ack = 0;

   always #5 clk = ~clk;

   prim_clock_switch_ctrl #(
      .NumClks   (N),
      .GateCycles(G),
      .DefaultSel(DEF)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .req_i (req),
      .sel_i (sel_in),
      .ack_o (ack),
      .err_o (err),
      .busy_o(busy),
      .sel_o (sel_out),
      .en_o  (en)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Timeline model: a switch accepted at edge s is fully described by d = e - s.
   int e = 0, d = 0;
   int m_cur = DEF, m_tgt = DEF, m_start = -1, m_ack_at = -9, m_err_at = -9;
   int x_sel = DEF, x_en = 1 << DEF, x_busy = 0, x_ack = 0, x_err = 0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         e = 0; m_cur = DEF; m_tgt = DEF; m_start = -1; m_ack_at = -9; m_err_at = -9;
      end else begin
         e++;
         if (m_start >= 0 && e > m_start + 2 * G) begin
            m_cur   = m_tgt;
            m_start = -1;
         end
         if (m_start < 0 && req) begin
            if (int'(sel_in) >= N)        m_err_at = e;
            else if (int'(sel_in) == m_cur) m_ack_at = e;
            else begin
               m_start = e;
               m_tgt   = int'(sel_in);
            end
         end
      end
      if (m_start >= 0) begin
         d      = e - m_start;
         x_sel  = (d >= G) ? m_tgt : m_cur;
         x_en   = (d == 2 * G) ? (1 << m_tgt) : 0;
         x_busy = (d < 2 * G) ? 1 : 0;
         x_ack  = (d == 2 * G) ? 1 : 0;
         x_err  = 0;
      end else begin
         x_sel  = m_cur;
         x_en   = 1 << m_cur;
         x_busy = 0;
         x_ack  = (m_ack_at == e) ? 1 : 0;
         x_err  = (m_err_at == e) ? 1 : 0;
      end
   end

   logic [SW-1:0] prev_sel = '0;
   logic [N-1:0]  prev_en  = '0;
   bit            prev_ok  = 0;

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("sel_o", sel_out, x_sel);
         chk("en_o", en, x_en);
         chk("busy_o", busy, x_busy);
         chk("ack_o", ack, x_ack);
         chk("err_o", err, x_err);
         chk("en_onehot0", 32'($onehot0(en)), 1);
         if (prev_ok && sel_out != prev_sel) begin
            chk("en_before_selchg", prev_en, 0);
            chk("en_after_selchg", en, 0);
         end
         if (ack) n_ack++;
         prev_sel = sel_out;
         prev_en  = en;
         prev_ok  = 1;
      end else begin
         prev_ok = 0;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int s);
      req    = 1'b1;
      sel_in = SW'(s);
      @(negedge clk);
      req    = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk(tag, busy, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sel"}, sel_out, DEF);
      chk({tag, "_en"}, en, 1 << DEF);
      chk({tag, "_ack"}, ack, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int a0;
      int k;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst_hold");
      rst_n = 1'b1;
      idle(2);
      chk_reset_vals("rst_after");

      // Full switch 2 -> 1 with explicit timeline points.
      pulse(1);
      chk("sw_en_T1", en, 0);
      chk("sw_busy_T1", busy, 1);
      idle(G);
      chk("sw_sel_TG1", sel_out, 1);
      idle(G);
      chk("sw_en_done", en, 5'b00010);
      chk("sw_ack", ack, 1);
      idle(1);

      // No-op and error requests.
      pulse(1);
      chk("noop_ack", ack, 1);
      chk("noop_en", en, 5'b00010);
      idle(1);
      pulse(6);
      chk("err_pulse", err, 1);
      chk("err_sel", sel_out, 1);
      idle(2);

      // Request while busy is dropped.
      a0 = n_ack;
      pulse(3);
      idle(1);
      pulse(0);
      wait_idle("busy_ign_timeout");
      idle(2);
      chk("busy_ign_acks", n_ack - a0, 1);
      chk("busy_ign_sel", sel_out, 3);

      // Back-to-back: second request in the ack cycle.
      pulse(4);
      k = 0;
      while (!ack && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("b2b_first_ack", ack, 1);
      pulse(0);
      chk("b2b_en_drop", en, 0);
      chk("b2b_busy", busy, 1);
      idle(2 * G);
      chk("b2b_ack2", ack, 1);
      chk("b2b_sel2", sel_out, 0);
      idle(1);

      // Asynchronous reset in the middle of DRAIN.
      pulse(3);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("async_rst");
      a0 = n_ack;
      @(negedge clk);
      rst_n = 1'b1;
      idle(3 * G);
      chk("async_rst_no_ack", n_ack - a0, 0);
      chk("async_rst_sel", sel_out, DEF);

      // Random traffic, including held requests and requests while busy.
      repeat (800) begin
         if ($urandom_range(0, 3) == 0) begin
            req    = 1'b1;
            sel_in = SW'($urandom_range(0, 7));
         end else begin
            req = 1'b0;
         end
         @(negedge clk);
      end
      req = 1'b0;
      idle(2 * G + 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prim_clock_switch_ctrl.md
# prim_clock_switch_ctrl

Sequencing controller for an N-input glitch-free clock selection network. It runs on a free-running reference clock and accepts select requests over a request/acknowledge handshake. For each switch it gates off all clock buffers, waits for the old clock to drain, moves the mux select, waits for the new path to settle, then re-enables exactly one buffer. Its `sel_o` / `en_o` drive a tree of 2:1 clock muxes and per-source buffer enables (BUFGCE-style) in the clocking subsystem.

## Interface
Parameters:
- `NumClks`, 4: number of selectable clock sources; legal range 2..8.
- `SelW`, $clog2(NumClks): width of select fields; derived, do not override.
- `GateCycles`, 4: reference-clock cycles spent in each of the DRAIN and SETTLE phases; legal range 1..255.
- `DefaultSel`, 0: source selected and enabled out of reset; must be < `NumClks`.

Ports:
- `clk_i` in 1: free-running reference clock; never one of the switched clocks.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `req_i` in 1: switch request; sampled only in IDLE.
- `sel_i` in SelW: requested source index; sampled with `req_i`.
- `ack_o` out 1: one-cycle pulse when a request completes successfully, including a no-op request.
- `err_o` out 1: one-cycle pulse when a request is rejected because `sel_i` >= `NumClks`.
- `busy_o` out 1: high while a switch sequence is in progress.
- `sel_o` out SelW: select to the clock mux tree; registered.
- `en_o` out NumClks: per-source buffer enables; registered; always one-hot or all-zero.

## Operation
- States: IDLE, DRAIN, SETTLE. State is held in a registered FSM with an 8-bit down-counter `cnt`.
- Reset values (asynchronous, while `rst_ni`=0):
  - `state`=IDLE, `cnt`=0.
  - `sel_o`=DefaultSel, `en_o`=1<<DefaultSel.
  - `ack_o`=0, `err_o`=0, `busy_o`=0.
- IDLE, with `req_i`=1, decides on the sampled `sel_i`:
  - `sel_i` >= NumClks: `err_o`=1 next cycle; no other change; stay in IDLE.
  - `sel_i` == `sel_o`: `ack_o`=1 next cycle; `en_o`/`sel_o` unchanged; stay in IDLE.
  - Otherwise: latch `sel_i` into `tgt`; `en_o`<=0; `cnt`<=GateCycles-1; `busy_o`<=1; go to DRAIN.
- DRAIN:
  - `cnt`≠0: decrement.
  - `cnt`=0: `sel_o`<=`tgt`; `cnt`<=GateCycles-1; go to SETTLE.
- SETTLE:
  - `cnt`≠0: decrement.
  - `cnt`=0: `en_o`<=1<<`tgt`; `ack_o`<=1; `busy_o`<=0; go to IDLE.
- `req_i` outside IDLE is ignored and not queued. The requester must see `ack_o` or `err_o` before issuing the next request.
- `req_i` held high in IDLE is treated as a new request every cycle. Requesters pulse `req_i` for one cycle.
- `en_o` is never non-zero while `sel_o` changes. `sel_o` changes only on the DRAIN→SETTLE transition.
- `ack_o` and `err_o` are mutually exclusive and never high for two consecutive cycles from the same request.
- Reset asserted mid-sequence: all outputs return to reset values immediately. No ack is issued for the aborted request.

## Timing
- Request sampled at edge T (valid switch):
  - T+1: `en_o`=0, `busy_o`=1.
  - T+G+1: `sel_o`=new.
  - T+2G+1: `en_o`=one-hot new, `ack_o`=1, `busy_o`=0.
  - G = GateCycles; total latency 2G+1 cycles.
- A new request is accepted at earliest at edge T+2G+1, i.e. in the same cycle `ack_o` is high. This allows back-to-back switches with a 2G+1-cycle period.
- No-op request and error request each respond at T+1 with a 1-cycle pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, NumClks=4, DefaultSel=2: during and after reset, `sel_o`=2, `en_o`=4'b0100, `ack_o`=`err_o`=`busy_o`=0.
- Switch, GateCycles=3: req with `sel_i`=1 at T. Required: `en_o`=0 for T+1..T+6; `sel_o`=1 from T+4; `en_o`=4'b0010 and `ack_o`=1 at T+7; `busy_o` high T+1..T+6.
- No-op and error: req `sel_i`=`sel_o` -> `ack_o` pulse at T+1, `en_o` unchanged. NumClks=5 with `sel_i`=6 -> `err_o` pulse at T+1, no state change.
- Busy ignore: req `sel_i`=3, then req `sel_i`=0 at T+2. Required: only the switch to 3 completes; single `ack_o`; final `sel_o`=3.
- Back-to-back: second req issued in the `ack_o` cycle is accepted. Required: `en_o` drops to 0 the next cycle, and the second switch completes after a further 2G+1 cycles.
- Async reset mid-DRAIN (`rst_ni` low between clock edges): outputs return to reset values without a clock edge, and no `ack_o` follows. Assert throughout all tests: `en_o` is one-hot or zero, and `en_o`=0 at every edge where `sel_o` changes.
